// File: rtl/maxnet_pkg.sv
// Shared constants for the Maxnet feeder: FSM encoding and parameter defaults.
package maxnet_pkg;
  localparam int DW_DEF       = 5;
  localparam int MAX_WAIT_DEF = 64;
  localparam int NUM_X        = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;
endpackage

// File: rtl/maxnet_feeder_ctrl.sv
// Feeder sequencing: sample counter, wait timer and the LOAD/START/WAIT/HOLD FSM.
module maxnet_feeder_ctrl
  import maxnet_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             mx_done,
  input  logic             res_ready,
  output logic             in_ready,
  output logic             mx_start,
  output logic             busy,
  output logic [NUM_X-1:0] x_en,
  output logic             w_en,
  output logic             cap_en,
  output logic             timeout,
  output logic             res_clr
);
  localparam int WCW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  state_e         state, state_n;
  logic [1:0]     cnt;
  logic [WCW-1:0] wait_cnt;
  logic           hs, at_limit;

  assign hs       = in_valid && in_ready;
  assign at_limit = (wait_cnt == WCW'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == LOAD && hs) cnt <= cnt + 2'd1;  // wraps to 0 after the 4th sample
      if (state == START)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      LOAD:  if (hs && cnt == 2'd3) state_n = START;
      START: state_n = WAIT;
      WAIT:  if (mx_done || at_limit) state_n = (mx_done ? HOLD : LOAD);
      HOLD:  if (res_ready) state_n = LOAD;
      default: state_n = LOAD;
    endcase
  end

  // in_ready is gated by rst so nothing is offered while reset is held.
  always_comb begin
    in_ready = (state == LOAD) && !rst;
    mx_start = (state == START);
    busy     = (state != LOAD);
    x_en     = '0;
    if (state == LOAD && hs) x_en[cnt] = 1'b1;
    w_en     = (state == LOAD) && hs && (cnt == 2'd0);
    cap_en   = (state == WAIT) && mx_done;
    timeout  = (state == WAIT) && !mx_done && at_limit;
    res_clr  = (state == HOLD) && res_ready;
  end
endmodule

// File: rtl/maxnet_feeder.sv
// Maxnet upstream stage: gathers four serial samples plus weights, starts Maxnet,
// and holds its result until the consumer takes it.
module maxnet_feeder
  import maxnet_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] w_in1,
  input  logic [DW-1:0] w_in2,
  output logic [DW-1:0] x1,
  output logic [DW-1:0] x2,
  output logic [DW-1:0] x3,
  output logic [DW-1:0] x4,
  output logic [DW-1:0] w1,
  output logic [DW-1:0] w2,
  output logic          mx_start,
  input  logic          mx_done,
  input  logic [DW-1:0] mx_max,
  output logic [DW-1:0] res_max,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          busy,
  output logic          err
);
  logic [NUM_X-1:0][DW-1:0] x_q;
  logic [NUM_X-1:0]         x_en;
  logic                     w_en, cap_en, timeout, res_clr;

  maxnet_feeder_ctrl #(.MAX_WAIT(MAX_WAIT)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .mx_done   (mx_done),
    .res_ready (res_ready),
    .in_ready  (in_ready),
    .mx_start  (mx_start),
    .busy      (busy),
    .x_en      (x_en),
    .w_en      (w_en),
    .cap_en    (cap_en),
    .timeout   (timeout),
    .res_clr   (res_clr)
  );

  for (genvar g = 0; g < NUM_X; g++) begin : g_lane
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         x_q[g] <= '0;
      else if (x_en[g]) x_q[g] <= in_data;
    end
  end

  assign x1 = x_q[0];
  assign x2 = x_q[1];
  assign x3 = x_q[2];
  assign x4 = x_q[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w1        <= '0;
      w2        <= '0;
      res_max   <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (w_en) begin
        w1 <= w_in1;
        w2 <= w_in2;
      end
      if (cap_en) begin
        res_max   <= mx_max;
        res_valid <= 1'b1;
      end else if (res_clr) begin
        res_valid <= 1'b0;
      end
      if (timeout) err <= 1'b1;  // sticky until reset
    end
  end
endmodule

// File: tb/tb_maxnet_feeder.sv
// Directed bench for maxnet_feeder: loading, start/done handshake, timeout, reset.
module tb_maxnet_feeder;
  localparam int DW = 5;
  localparam int MAX_WAIT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data, w_in1, w_in2, mx_max;
  logic          in_valid, mx_done, res_ready;
  logic          in_ready, mx_start, res_valid, busy, err;
  logic [DW-1:0] x1, x2, x3, x4, w1, w2, res_max;

  int n_cmp = 0;
  int n_err = 0;

  maxnet_feeder #(.DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .w_in1(w_in1), .w_in2(w_in2), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .w1(w1), .w2(w2),
    .mx_start(mx_start), .mx_done(mx_done), .mx_max(mx_max), .res_max(res_max),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [DW-1:0] a, b, c, d, input logic [DW-1:0] wa, wb);
    logic [DW-1:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      w_in1    = (i == 0) ? wa : 5'd7;
      w_in2    = (i == 0) ? wb : 5'd7;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_x(input string tag, input logic [DW-1:0] a, b, c, d);
    chk({tag, ".x1"}, 32'(x1), 32'(a));
    chk({tag, ".x2"}, 32'(x2), 32'(b));
    chk({tag, ".x3"}, 32'(x3), 32'(c));
    chk({tag, ".x4"}, 32'(x4), 32'(d));
  endtask

  initial begin
    int hs, cyc;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; w_in1 = '0; w_in2 = '0;
    mx_done = 1'b0; mx_max = '0; res_ready = 1'b0;
    repeat (2) tick();
    chk("rst.in_ready", 32'(in_ready), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.mx_start", 32'(mx_start), 0);
    chk("rst.res_valid", 32'(res_valid), 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.x1", 32'(x1), 0);
    rst = 1'b0;
    #1;
    chk("idle.in_ready", 32'(in_ready), 1);

    // 1: back-to-back load, weights from the first beat only
    load4(5'd3, 5'd17, 5'd9, 5'd22, 5'd1, 5'd31);
    chk("t1.mx_start", 32'(mx_start), 1);
    chk("t1.in_ready", 32'(in_ready), 0);
    chk_x("t1", 5'd3, 5'd17, 5'd9, 5'd22);
    chk("t1.w1", 32'(w1), 1);
    chk("t1.w2", 32'(w2), 31);
    tick();
    chk("t1.start_once", 32'(mx_start), 0);
    chk("t1.busy", 32'(busy), 1);

    // 2: done five cycles after start, result held until consumed
    repeat (3) tick();
    mx_done = 1'b1; mx_max = 5'd22;
    chk("t2.pre_valid", 32'(res_valid), 0);
    tick();
    mx_done = 1'b0; mx_max = 5'd0;
    for (int i = 0; i < 3; i++) begin
      chk("t2.res_valid", 32'(res_valid), 1);
      chk("t2.res_max", 32'(res_max), 22);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t2.res_drop", 32'(res_valid), 0);
    chk("t2.in_ready", 32'(in_ready), 1);

    // 3: gapped stream 1,0,1,0,1,0,1
    hs = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 5'(5 + i / 2);
      w_in1    = (i == 0) ? 5'd10 : 5'd20;
      w_in2    = (i == 0) ? 5'd11 : 5'd21;
      if (in_valid && in_ready) hs++;
      tick();
    end
    in_valid = 1'b0;
    chk("t3.handshakes", 32'(hs), 4);
    chk("t3.mx_start", 32'(mx_start), 1);
    chk_x("t3", 5'd5, 5'd6, 5'd7, 5'd8);
    chk("t3.w1", 32'(w1), 10);
    chk("t3.w2", 32'(w2), 11);

    // done on the very last allowed WAIT cycle wins over the timeout
    tick();
    repeat (MAX_WAIT - 1) tick();
    mx_done = 1'b1; mx_max = 5'd8;
    tick();
    mx_done = 1'b0;
    chk("lim.res_valid", 32'(res_valid), 1);
    chk("lim.res_max", 32'(res_max), 8);
    chk("lim.err", 32'(err), 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // 4: timeout
    load4(5'd1, 5'd2, 5'd3, 5'd4, 5'd0, 5'd0);
    tick();
    cyc = 0;
    while (busy && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("t4.wait_cycles", 32'(cyc), MAX_WAIT);
    chk("t4.err", 32'(err), 1);
    chk("t4.res_valid", 32'(res_valid), 0);
    load4(5'd30, 5'd29, 5'd28, 5'd27, 5'd2, 5'd3);
    tick();
    mx_done = 1'b1; mx_max = 5'd30;
    tick();
    mx_done = 1'b0;
    chk("t4.res_max", 32'(res_max), 30);
    chk("t4.res_valid", 32'(res_valid), 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t4.err_sticky", 32'(err), 1);

    // 5: done outside WAIT is ignored
    mx_done = 1'b1; mx_max = 5'd9;
    tick();
    mx_done = 1'b0;
    chk("t5.load_valid", 32'(res_valid), 0);
    chk("t5.load_busy", 32'(busy), 0);
    load4(5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'd0);
    mx_done = 1'b1; mx_max = 5'd13;
    tick();
    mx_done = 1'b0;
    chk("t5.start_valid", 32'(res_valid), 0);
    chk("t5.start_busy", 32'(busy), 1);
    tick();
    mx_done = 1'b1; mx_max = 5'd4;
    tick();
    mx_done = 1'b0;
    chk("t5.res_max", 32'(res_max), 4);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // 6: asynchronous reset mid-START, mid-WAIT and mid-load
    load4(5'd11, 5'd12, 5'd13, 5'd14, 5'd5, 5'd6);
    #2 rst = 1'b1;
    #1;
    chk("t6.start_drop", 32'(mx_start), 0);
    chk("t6.start_err", 32'(err), 0);
    tick();
    rst = 1'b0;
    load4(5'd11, 5'd12, 5'd13, 5'd14, 5'd5, 5'd6);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("t6.wait_busy", 32'(busy), 0);
    chk("t6.wait_x1", 32'(x1), 0);
    chk("t6.wait_w1", 32'(w1), 0);
    chk("t6.wait_res_max", 32'(res_max), 0);
    chk("t6.wait_in_ready", 32'(in_ready), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 5'(20 + i); w_in1 = 5'd9; w_in2 = 5'd9;
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6.part_x2", 32'(x2), 0);
    tick();
    rst = 1'b0;
    load4(5'd1, 5'd2, 5'd3, 5'd4, 5'd15, 5'd16);
    chk("t6.refill_start", 32'(mx_start), 1);
    chk_x("t6.refill", 5'd1, 5'd2, 5'd3, 5'd4);
    chk("t6.refill_w1", 32'(w1), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
